// File: rtl/seq_mult_bcd_pkg.sv
// Shared types and elaboration helpers for the sequential BCD multiplier.
package seq_mult_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      CONV = 2'd2,
      DONE = 2'd3
   } state_t;

   // Smallest digit count d with 10^d > (2^width - 1)^2; valid for width <= 63.
   function automatic int min_digits(input int width);
      logic [127:0] max_prod;
      logic [127:0] pow10;
      int           d;
      max_prod = ((128'd1 << width) - 128'd1) * ((128'd1 << width) - 128'd1);
      pow10    = 128'd1;
      d        = 0;
      while ((pow10 <= max_prod) && (d < 40)) begin
         pow10 = pow10 * 128'd10;
         d     = d + 1;
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_double_dabble.sv
// Sequential binary-to-packed-BCD converter, one input bit per cycle, MSB first.
module seq_double_dabble
   import seq_mult_bcd_pkg::*;
#(
   parameter int IN_W   = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [IN_W-1:0]       bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(IN_W + 1);

   logic [IN_W-1:0]     shreg;
   logic [CW-1:0]       remaining;
   logic [4*DIGITS-1:0] adjusted;

   function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign adjusted = add3(bcd);

   // High during the cycle whose closing edge performs the final shift.
   assign done = busy && (remaining == CW'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg     <= '0;
         bcd       <= '0;
         remaining <= '0;
         busy      <= 1'b0;
      end else if (load) begin
         shreg     <= bin;
         bcd       <= '0;
         remaining <= CW'(IN_W);
         busy      <= 1'b1;
      end else if (busy) begin
         {bcd, shreg} <= {adjusted, shreg} << 1;
         remaining    <= remaining - CW'(1);
         if (remaining == CW'(1)) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_mult_bcd.sv
// Sequential shift-add multiplier with signed/unsigned operands and BCD result.
//   state | meaning
//   IDLE  | waiting for start, results held
//   MULT  | WIDTH shift-add iterations on operand magnitudes
//   CONV  | double-dabble of the product magnitude in progress
//   DONE  | register results, pulse done
module seq_mult_bcd
   import seq_mult_bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [WIDTH-1:0]      multiplier,
   input  logic [WIDTH-1:0]      multiplicand,
   output logic                  busy,
   output logic                  done,
   output logic [2*WIDTH-1:0]    product,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  negative,
   output logic                  zero
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW + 1);

   if (WIDTH < 2) begin : g_bad_width
      $error("seq_mult_bcd: WIDTH must be at least 2");
   end
   if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
      $error("seq_mult_bcd: DIGITS too small for WIDTH");
   end

   state_t              state;
   logic                sign;
   logic [WIDTH-1:0]    mpl;
   logic [PW-1:0]       mcand_sh;
   logic [PW-1:0]       acc;
   logic [PW-1:0]       acc_next;
   logic [CW-1:0]       iter;
   logic                dd_load;
   logic                dd_busy;
   logic                dd_done;
   logic [4*DIGITS-1:0] dd_bcd;

   // Most negative two's complement value maps to 2^(WIDTH-1) as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   always_comb begin
      acc_next = acc;
      if (mpl[0]) acc_next = acc + mcand_sh;
   end

   // Converter is loaded with the final sum on the last MULT edge.
   assign dd_load = (state == MULT) && (iter == CW'(WIDTH - 1));

   seq_double_dabble #(
      .IN_W   (PW),
      .DIGITS (DIGITS)
   ) u_dd (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (dd_load),
      .bin     (acc_next),
      .busy    (dd_busy),
      .done    (dd_done),
      .bcd     (dd_bcd)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         sign     <= 1'b0;
         mpl      <= '0;
         mcand_sh <= '0;
         acc      <= '0;
         iter     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
         bcd      <= '0;
         negative <= 1'b0;
         zero     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign     <= is_signed & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                  mpl      <= magnitude(multiplier, is_signed);
                  mcand_sh <= {{WIDTH{1'b0}}, magnitude(multiplicand, is_signed)};
                  acc      <= '0;
                  iter     <= '0;
                  busy     <= 1'b1;
                  state    <= MULT;
               end
            end
            MULT: begin
               acc      <= acc_next;
               mpl      <= mpl >> 1;
               mcand_sh <= mcand_sh << 1;
               if (iter == CW'(WIDTH - 1)) begin
                  iter  <= '0;
                  state <= CONV;
               end else begin
                  iter <= iter + CW'(1);
               end
            end
            CONV: begin
               if (dd_done || !dd_busy) begin
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               product  <= (sign && (acc != '0)) ? (~acc + PW'(1)) : acc;
               bcd      <= dd_bcd;
               zero     <= (acc == '0);
               negative <= sign && (acc != '0);
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_bcd.sv
// Bench for seq_mult_bcd: directed vector table, handshake corner cases, random vs. arithmetic model.
module tb_seq_mult_bcd;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 5;
   localparam int LAT    = 3 * WIDTH + 1;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        is_signed;
   logic [7:0]  multiplier;
   logic [7:0]  multiplicand;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [19:0] bcd;
   logic        negative;
   logic        zero;

   int total = 0;
   int bad   = 0;

   seq_mult_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .is_signed    (is_signed),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .bcd          (bcd),
      .negative     (negative),
      .zero         (zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        s;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      logic [19:0] d;
      logic        neg;
      logic        zr;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic reference.
   task automatic model(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output logic [19:0] d,
                        output logic neg, output logic zr);
      int ai, bi, pi, m;
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      pi = ai * bi;
      p  = 16'(pi);
      m  = (pi < 0) ? -pi : pi;
      d  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         d[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      neg = (pi < 0);
      zr  = (pi == 0);
   endtask

   // Issue one operation, scramble inputs afterwards, wait for done (bounded).
   task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_cnt, output logic busy_at_done);
      @(negedge clock);
      start = 1'b1; is_signed = s; multiplier = a; multiplicand = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      is_signed = 1'($urandom); multiplier = 8'($urandom); multiplicand = 8'($urandom);
      lat = -1; busy_cnt = 0; busy_at_done = 1'b0;
      for (int k = 0; k <= 60 && lat < 0; k++) begin
         if (k > 0) begin
            @(posedge clock);
            #1;
         end
         if (busy) busy_cnt++;
         if (done) begin
            lat = k;
            busy_at_done = busy;
         end
      end
   endtask

   task automatic check_result(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] ep, input logic [19:0] ed,
                               input logic en, input logic ez);
      int   lat, bc;
      logic bd;
      do_op(s, a, b, lat, bc, bd);
      chk({tag, " latency"}, 32'(lat), 32'(LAT));
      chk({tag, " busy_cycles"}, 32'(bc), 32'(3 * WIDTH));
      chk({tag, " busy_in_done"}, 32'(bd), 32'd0);
      chk({tag, " product"}, 32'(product), 32'(ep));
      chk({tag, " bcd"}, 32'(bcd), 32'(ed));
      chk({tag, " negative"}, 32'(negative), 32'(en));
      chk({tag, " zero"}, 32'(zero), 32'(ez));
   endtask

   vec_t vecs[8];

   initial begin
      int   dcount, first_k, second_k;
      logic [15:0] mp;
      logic [19:0] md;
      logic        mn, mz;
      logic        rs;
      logic [7:0]  ra, rb;

      vecs[0] = '{1'b1, 8'd12,   8'd11,   16'd132,   20'h00132, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'hFD,   8'd5,    16'hFFF1,  20'h00015, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'h80,   8'h80,   16'd16384, 20'h16384, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'hFF,   8'hFF,   16'hFE01,  20'h65025, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'hFF,   8'hFF,   16'h0001,  20'h00001, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 8'h00,   8'hF9,   16'h0000,  20'h00000, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 8'h80,   8'h02,   16'h0100,  20'h00256, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h7F,   8'h80,   16'hC080,  20'h16256, 1'b1, 1'b0};

      reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; multiplier = '0; multiplicand = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset outputs", {7'd0, product, 1'b0, bcd[7:0], negative, zero}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         check_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                      vecs[i].p, vecs[i].d, vecs[i].neg, vecs[i].zr);
      end

      // Starts during MULT and DONE are dropped; a start right after DONE is accepted.
      @(negedge clock);
      start = 1'b1; is_signed = 1'b1; multiplier = 8'd12; multiplicand = 8'd11;
      @(posedge clock);
      #1;
      start = 1'b0;
      dcount = 0; first_k = -1; second_k = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         start = 1'b0;
         if (k == 5 || k == 25) begin
            start = 1'b1; multiplier = 8'd3; multiplicand = 8'd3;
         end
         if (k == 26) begin
            start = 1'b1; is_signed = 1'b0; multiplier = 8'd3; multiplicand = 8'd3;
         end
         @(posedge clock);
         #1;
         if (done) begin
            dcount++;
            if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
            if (k == 25) begin
               chk("ignored start product", 32'(product), 32'd132);
               chk("ignored start bcd", 32'(bcd), 32'h00132);
            end
            if (k == 51) begin
               chk("back2back product", 32'(product), 32'd9);
               chk("back2back bcd", 32'(bcd), 32'h00009);
            end
         end
      end
      start = 1'b0;
      chk("done pulse count", 32'(dcount), 32'd2);
      chk("first done edge", 32'(first_k), 32'd25);
      chk("second done edge", 32'(second_k), 32'd51);

      // Asynchronous reset in the middle of conversion.
      @(negedge clock);
      start = 1'b1; is_signed = 1'b1; multiplier = 8'd12; multiplicand = 8'd11;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      chk("midreset busy", 32'(busy), 32'd0);
      chk("midreset done", 32'(done), 32'd0);
      chk("midreset product", 32'(product), 32'd0);
      chk("midreset bcd", 32'(bcd), 32'd0);
      chk("midreset flags", {30'd0, negative, zero}, 32'd0);
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clock);
         #1;
         if (done || busy) dcount++;
      end
      chk("midreset quiet", 32'(dcount), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      check_result("after reset 7x9", 1'b0, 8'd7, 8'd9, 16'd63, 20'h00063, 1'b0, 1'b0);

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i == 0) ra = 8'h80;
         if (i == 1) rb = 8'h00;
         model(rs, ra, rb, mp, md, mn, mz);
         check_result($sformatf("rand%0d s=%0d a=%0h b=%0h", i, rs, ra, rb), rs, ra, rb, mp, md, mn, mz);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
